pipe_fetch_buffer: RTL

Instruction fetch stage with a parametrised prefetch buffer, sitting between the core's program-counter control and the instruction memory port. Sequentially prefetches up to BUFFER_DEPTH instructions ahead of the pipeline, hands one instruction per pipe step to decode, and flushes and restarts on a redirect (branch, jump, trap). Replaces the single-entry cached fetch with a fully synchronous, single-edge design.

---
 rtl/pipe_fetch_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipe_fetch_buffer.sv
// pipe_fetch_buffer
//   Instruction fetch stage with a BUFFER_DEPTH-entry prefetch buffer. It
//   fetches instructions sequentially ahead of the pipeline and hands one to
//   decode per pipe step. A redirect flushes the buffer and restarts fetching
//   at a new address. Only one memory request is outstanding at a time.
//
// Parameters
//   PROGRAM_COUNTER_RESET  fetch address after reset
//   BUFFER_DEPTH           prefetch entries (power of two, >= 2)
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   run                    permits new fetch requests
//   stepPipe, pipeStall    pipeline advance / insert-bubble controls
//   redirect,
//   redirectAddress        flush and restart fetch at redirectAddress
//   currentPipeStall       last step issued a bubble
//   lastInstruction,
//   lastProgramCounter     instruction handed to decode and its address
//   instructionValid       buffer non-empty
//   bufferLevel            entries currently held
//   addressMisaligned      fetch PC not word aligned (fetching halted)
//   fetchAddress,
//   fetchEnable            registered memory request
//   fetchBusy, fetchData   memory handshake / read data
module pipe_fetch_buffer #(
  parameter logic [31:0] PROGRAM_COUNTER_RESET = 32'b0,
  parameter int          BUFFER_DEPTH          = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              run,
  input  logic                              stepPipe,
  input  logic                              pipeStall,
  input  logic                              redirect,
  input  logic [31:0]                       redirectAddress,
  output logic                              currentPipeStall,
  output logic [31:0]                       lastInstruction,
  output logic [31:0]                       lastProgramCounter,
  output logic                              instructionValid,
  output logic [$clog2(BUFFER_DEPTH):0]     bufferLevel,
  output logic                              addressMisaligned,
  output logic [31:0]                       fetchAddress,
  output logic                              fetchEnable,
  input  logic                              fetchBusy,
  input  logic [31:0]                       fetchData
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(BUFFER_DEPTH);

  logic [31:0]      fetch_pc;
  logic             discard_pending;
  logic [31:0]      buf_pc    [BUFFER_DEPTH];
  logic [31:0]      buf_instr [BUFFER_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [LVL_W-1:0] level;

  logic             completion;
  logic             request_held;
  logic             push;
  logic             pop;
  logic             issue;
  logic [LVL_W-1:0] level_next;
  logic [31:0]      pc_next;

  always_comb begin
    completion   = fetchEnable & ~fetchBusy;
    request_held = fetchEnable & fetchBusy;
    // Data returning for a request that predates a redirect (earlier or in
    // this very cycle) belongs to the abandoned stream and is dropped.
    push         = completion & ~discard_pending & ~redirect;
    pop          = stepPipe & ~pipeStall & (level != '0) & ~redirect;

    level_next = level;
    if (redirect) begin
      level_next = '0;
    end else begin
      level_next = level + LVL_W'(push) - LVL_W'(pop);
    end

    pc_next = fetch_pc;
    if (redirect) begin
      pc_next = redirectAddress;
    end else if (push) begin
      pc_next = fetch_pc + 32'd4;
    end

    // Issue decisions look at next-cycle PC and level so a completing
    // request can be followed back-to-back by the next one.
    issue = ~request_held & run & (pc_next[1:0] == 2'b00) &
            (level_next < DEPTH_LVL);
  end

  assign addressMisaligned = |fetch_pc[1:0];
  assign instructionValid  = (level != '0);
  assign bufferLevel       = level;

  // Buffer storage has no reset; occupancy is tracked by head/tail/level.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[tail]    <= fetchAddress;
      buf_instr[tail] <= fetchData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc           <= PROGRAM_COUNTER_RESET;
      discard_pending    <= 1'b0;
      head               <= '0;
      tail               <= '0;
      level              <= '0;
      fetchEnable        <= 1'b0;
      fetchAddress       <= 32'b0;
      currentPipeStall   <= 1'b1;
      lastInstruction    <= ~32'b0;
      lastProgramCounter <= 32'b0;
    end else begin
      fetch_pc <= pc_next;
      level    <= level_next;

      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
      end

      // Stays set only while the stale request is still waiting on the bus.
      discard_pending <= request_held & (discard_pending | redirect);

      // A busy request keeps its address; otherwise decide on a new one.
      if (!request_held) begin
        fetchEnable <= issue;
        if (issue) fetchAddress <= pc_next;
      end

      if (stepPipe) begin
        if (pop) begin
          lastInstruction    <= buf_instr[head];
          lastProgramCounter <= buf_pc[head];
          currentPipeStall   <= 1'b0;
        end else begin
          lastInstruction    <= ~32'b0;
          currentPipeStall   <= 1'b1;
        end
      end
    end
  end

endmodule
